// File: rtl/rom_stream_reader.sv
// rom_stream_reader: streams a run of words from a fixed-latency read port
// onto a valid/ready output with last-word marking, abort and restart.
module rom_stream_reader #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]      state;
    logic [ADDR_W:0] remaining;
    logic [2:0]      lat_cnt;
    assign busy = (state == WAIT) || (state == VALID);
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rom_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            lat_cnt   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    done <= (length == '0);
                    if (length == '0) begin
                        state <= DONE;
                    end else begin
                        rom_addr  <= base_addr;
                        remaining <= length;
                        lat_cnt   <= 3'(READ_LAT);
                        state     <= WAIT;
                    end
                end
                // lat_cnt reaching zero marks the (READ_LAT+1)-th edge after rom_addr moved
                WAIT: if (lat_cnt == '0) begin
                    out_data  <= rom_q;
                    out_valid <= 1'b1;
                    out_last  <= (remaining == (ADDR_W+1)'(1));
                    state     <= VALID;
                end else begin
                    lat_cnt <= lat_cnt - 3'd1;
                end
                VALID: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    remaining <= remaining - (ADDR_W+1)'(1);
                    if (out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        lat_cnt  <= 3'(READ_LAT);
                        state    <= WAIT;
                    end
                end
            endcase
        end
    end
endmodule
